// File: rtl/ddr3_axi_req_pkg.sv
// Shared constants and types for the DDR3 AXI request sequencer.
// Burst encodings follow AXI4; stride is in 16-bit DDR-word units.
package ddr3_axi_req_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } seq_state_e;

  localparam int unsigned BL8_STRIDE    = 8;
  localparam int unsigned BEATS_PER_BL8 = 4;

endpackage

// File: rtl/ddr3_axi_seq.sv
// One AXI address channel sequencer: latches an INCR burst and issues one
// BL8 request per four AXI beats to the DDR3 FSM request/ack port.
module ddr3_axi_seq
  import ddr3_axi_req_pkg::*;
#(
  parameter int ADDRS  = 22,
  parameter int REQID  = 4,
  parameter int STRIDE = BL8_STRIDE
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [REQID-1:0] i_id,
  input  logic [7:0]       i_len,
  input  logic [1:0]       i_burst,
  input  logic [ADDRS:0]   i_addr,
  output logic             o_req,
  input  logic             i_ack,
  output logic             o_lst,
  input  logic             i_err,
  output logic [REQID-1:0] o_tid,
  output logic [ADDRS-1:0] o_adr,
  output logic             o_abort
);

  localparam int LEN_SHIFT = $clog2(BEATS_PER_BL8);

  seq_state_e       r_state, w_nstate;
  logic [5:0]       r_cnt, w_ncnt;
  logic [ADDRS-1:0] r_adr, w_nadr;
  logic [REQID-1:0] r_tid, w_ntid;
  logic             r_abort, w_nabort;
  logic             r_ready;
  logic             w_unused;

  // Byte-address bits below the BL8 boundary never reach the FSM.
  assign w_unused = ^i_addr[3:0];

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_tid   <= '0;
      r_abort <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_adr   <= w_nadr;
      r_tid   <= w_ntid;
      r_abort <= w_nabort;
      r_ready <= (w_nstate == S_IDLE);
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nadr   = r_adr;
    w_ntid   = r_tid;
    w_nabort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid && r_ready) begin
          if (i_burst == BURST_INCR) begin
            w_ntid   = i_id;
            w_nadr   = {i_addr[ADDRS:4], 3'b000};
            w_ncnt   = 6'(i_len >> LEN_SHIFT);
            w_nstate = S_BUSY;
          end else begin
            w_nabort = 1'b1;
          end
        end
      end
      S_BUSY: begin
        // Error wins over a simultaneous ack and drops the rest of the burst.
        if (i_err) begin
          w_nabort = 1'b1;
          w_nstate = S_IDLE;
        end else if (i_ack) begin
          if (r_cnt == 6'd0) begin
            w_nstate = S_IDLE;
          end else begin
            w_nadr = r_adr + ADDRS'(STRIDE);
            w_ncnt = r_cnt - 6'd1;
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign o_ready = r_ready;
  assign o_req   = (r_state == S_BUSY);
  assign o_lst   = (r_state == S_BUSY) && (r_cnt == 6'd0);
  assign o_tid   = r_tid;
  assign o_adr   = r_adr;
  assign o_abort = r_abort;

endmodule

// File: rtl/ddr3_axi_req.sv
// AXI4 AW/AR to DDR3 FSM request splitter; write and read channels run
// independent copies of the same sequencer.
module ddr3_axi_req
  import ddr3_axi_req_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ADDRS = 22,
  parameter int REQID = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             axi_awvalid_i,
  output logic             axi_awready_o,
  input  logic [REQID-1:0] axi_awid_i,
  input  logic [7:0]       axi_awlen_i,
  input  logic [1:0]       axi_awburst_i,
  input  logic [ADDRS:0]   axi_awaddr_i,
  input  logic             axi_arvalid_i,
  output logic             axi_arready_o,
  input  logic [REQID-1:0] axi_arid_i,
  input  logic [7:0]       axi_arlen_i,
  input  logic [1:0]       axi_arburst_i,
  input  logic [ADDRS:0]   axi_araddr_i,
  output logic             mem_wrreq_o,
  input  logic             mem_wrack_i,
  output logic             mem_wrlst_o,
  input  logic             mem_wrerr_i,
  output logic [REQID-1:0] mem_wrtid_o,
  output logic [ADDRS-1:0] mem_wradr_o,
  output logic             mem_rdreq_o,
  input  logic             mem_rdack_i,
  output logic             mem_rdlst_o,
  input  logic             mem_rderr_i,
  output logic [REQID-1:0] mem_rdtid_o,
  output logic [ADDRS-1:0] mem_rdadr_o,
  output logic             wr_abort_o,
  output logic             rd_abort_o
);

  // DDR words advanced per BL8: (AXI bytes per beat / 2) * beats per BL8.
  localparam int STRIDE = (WIDTH / 16) * BEATS_PER_BL8;

  ddr3_axi_seq #(.ADDRS(ADDRS), .REQID(REQID), .STRIDE(STRIDE)) u_wr_seq (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_valid (axi_awvalid_i),
    .o_ready (axi_awready_o),
    .i_id    (axi_awid_i),
    .i_len   (axi_awlen_i),
    .i_burst (axi_awburst_i),
    .i_addr  (axi_awaddr_i),
    .o_req   (mem_wrreq_o),
    .i_ack   (mem_wrack_i),
    .o_lst   (mem_wrlst_o),
    .i_err   (mem_wrerr_i),
    .o_tid   (mem_wrtid_o),
    .o_adr   (mem_wradr_o),
    .o_abort (wr_abort_o)
  );

  ddr3_axi_seq #(.ADDRS(ADDRS), .REQID(REQID), .STRIDE(STRIDE)) u_rd_seq (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_valid (axi_arvalid_i),
    .o_ready (axi_arready_o),
    .i_id    (axi_arid_i),
    .i_len   (axi_arlen_i),
    .i_burst (axi_arburst_i),
    .i_addr  (axi_araddr_i),
    .o_req   (mem_rdreq_o),
    .i_ack   (mem_rdack_i),
    .o_lst   (mem_rdlst_o),
    .i_err   (mem_rderr_i),
    .o_tid   (mem_rdtid_o),
    .o_adr   (mem_rdadr_o),
    .o_abort (rd_abort_o)
  );

endmodule

// File: tb/tb_ddr3_axi_req.sv
// Directed self-checking bench for ddr3_axi_req: one task per scenario,
// expected values hand-computed from the AXI addresses and lengths.
module tb_ddr3_axi_req;
  import ddr3_axi_req_pkg::*;

  localparam int ADDRS = 22;
  localparam int REQID = 4;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             axi_awvalid_i, axi_arvalid_i;
  logic             axi_awready_o, axi_arready_o;
  logic [REQID-1:0] axi_awid_i, axi_arid_i;
  logic [7:0]       axi_awlen_i, axi_arlen_i;
  logic [1:0]       axi_awburst_i, axi_arburst_i;
  logic [ADDRS:0]   axi_awaddr_i, axi_araddr_i;
  logic             mem_wrreq_o, mem_wrack_i, mem_wrlst_o, mem_wrerr_i;
  logic [REQID-1:0] mem_wrtid_o, mem_rdtid_o;
  logic [ADDRS-1:0] mem_wradr_o, mem_rdadr_o;
  logic             mem_rdreq_o, mem_rdack_i, mem_rdlst_o, mem_rderr_i;
  logic             wr_abort_o, rd_abort_o;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ddr3_axi_req #(.WIDTH(32), .ADDRS(ADDRS), .REQID(REQID)) dut (
    .clock(clock), .rst_n(rst_n),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i),
    .axi_awburst_i(axi_awburst_i), .axi_awaddr_i(axi_awaddr_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i),
    .axi_arburst_i(axi_arburst_i), .axi_araddr_i(axi_araddr_i),
    .mem_wrreq_o(mem_wrreq_o), .mem_wrack_i(mem_wrack_i),
    .mem_wrlst_o(mem_wrlst_o), .mem_wrerr_i(mem_wrerr_i),
    .mem_wrtid_o(mem_wrtid_o), .mem_wradr_o(mem_wradr_o),
    .mem_rdreq_o(mem_rdreq_o), .mem_rdack_i(mem_rdack_i),
    .mem_rdlst_o(mem_rdlst_o), .mem_rderr_i(mem_rderr_i),
    .mem_rdtid_o(mem_rdtid_o), .mem_rdadr_o(mem_rdadr_o),
    .wr_abort_o(wr_abort_o), .rd_abort_o(rd_abort_o)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axi_awvalid_i = 0; axi_arvalid_i = 0;
    axi_awid_i = 0; axi_arid_i = 0; axi_awlen_i = 0; axi_arlen_i = 0;
    axi_awburst_i = 0; axi_arburst_i = 0; axi_awaddr_i = 0; axi_araddr_i = 0;
    mem_wrack_i = 0; mem_wrerr_i = 0; mem_rdack_i = 0; mem_rderr_i = 0;
    tick(); tick();
    checks++;
    if ({axi_awready_o, axi_arready_o, mem_wrreq_o, mem_rdreq_o, mem_wrlst_o, mem_rdlst_o,
         wr_abort_o, rd_abort_o} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
               {axi_awready_o, axi_arready_o, mem_wrreq_o, mem_rdreq_o, mem_wrlst_o,
                mem_rdlst_o, wr_abort_o, rd_abort_o});
    end
    checks++;
    if ({mem_wrtid_o, mem_rdtid_o, mem_wradr_o, mem_rdadr_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got wrtid=%h rdtid=%h wradr=%h rdadr=%h expected all 0",
               mem_wrtid_o, mem_rdtid_o, mem_wradr_o, mem_rdadr_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({axi_awready_o, axi_arready_o} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 11", {axi_awready_o, axi_arready_o});
    end
  endtask

  task automatic test_single();
    axi_awvalid_i = 1; axi_awid_i = 4'd2; axi_awlen_i = 8'd3;
    axi_awburst_i = BURST_INCR; axi_awaddr_i = 23'h40;
    tick();
    axi_awvalid_i = 0;
    checks++;
    if ({axi_awready_o, mem_wrreq_o, mem_wrlst_o, mem_wrtid_o, mem_wradr_o} !==
        {1'b0, 1'b1, 1'b1, 4'd2, 22'h20}) begin
      errors++;
      $display("[TB] FAIL single_req: got rdy=%b req=%b lst=%b tid=%h adr=%h expected 0 1 1 2 20",
               axi_awready_o, mem_wrreq_o, mem_wrlst_o, mem_wrtid_o, mem_wradr_o);
    end
    // The request must hold while unacknowledged.
    tick();
    checks++;
    if ({mem_wrreq_o, mem_wradr_o} !== {1'b1, 22'h20}) begin
      errors++;
      $display("[TB] FAIL single_hold: got req=%b adr=%h expected 1 20", mem_wrreq_o, mem_wradr_o);
    end
    mem_wrack_i = 1;
    tick();
    mem_wrack_i = 0;
    checks++;
    if ({mem_wrreq_o, axi_awready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_done: got req=%b rdy=%b expected 0 1", mem_wrreq_o, axi_awready_o);
    end
  endtask

  task automatic test_multi();
    logic [ADDRS-1:0] exp_adr;
    axi_awvalid_i = 1; axi_awid_i = 4'd7; axi_awlen_i = 8'd15;
    axi_awburst_i = BURST_INCR; axi_awaddr_i = 23'h100;
    tick();
    axi_awvalid_i = 0;
    mem_wrack_i = 1;
    for (int i = 0; i < 4; i++) begin
      exp_adr = 22'h80 + 22'(8 * i);
      checks++;
      if ({mem_wrreq_o, mem_wradr_o, mem_wrlst_o} !== {1'b1, exp_adr, (i == 3)}) begin
        errors++;
        $display("[TB] FAIL multi_req%0d: got req=%b adr=%h lst=%b expected 1 %h %b",
                 i, mem_wrreq_o, mem_wradr_o, mem_wrlst_o, exp_adr, (i == 3));
      end
      tick();
    end
    mem_wrack_i = 0;
    checks++;
    if ({mem_wrreq_o, axi_awready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL multi_done: got req=%b rdy=%b expected 0 1", mem_wrreq_o, axi_awready_o);
    end
  endtask

  task automatic test_wrap();
    axi_arvalid_i = 1; axi_arid_i = 4'd3; axi_arlen_i = 8'd7;
    axi_arburst_i = BURST_INCR; axi_araddr_i = 23'h7FFFF2;
    tick();
    axi_arvalid_i = 0;
    mem_rdack_i = 1;
    checks++;
    if ({mem_rdreq_o, mem_rdadr_o, mem_rdlst_o, mem_rdtid_o} !== {1'b1, 22'h3FFFF8, 1'b0, 4'd3}) begin
      errors++;
      $display("[TB] FAIL wrap_first: got req=%b adr=%h lst=%b tid=%h expected 1 3ffff8 0 3",
               mem_rdreq_o, mem_rdadr_o, mem_rdlst_o, mem_rdtid_o);
    end
    tick();
    checks++;
    if ({mem_rdreq_o, mem_rdadr_o, mem_rdlst_o} !== {1'b1, 22'h0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wrap_second: got req=%b adr=%h lst=%b expected 1 0 1",
               mem_rdreq_o, mem_rdadr_o, mem_rdlst_o);
    end
    tick();
    mem_rdack_i = 0;
    checks++;
    if ({mem_rdreq_o, axi_arready_o, mem_wrreq_o} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL wrap_done: got rdreq=%b ardy=%b wrreq=%b expected 0 1 0",
               mem_rdreq_o, axi_arready_o, mem_wrreq_o);
    end
  endtask

  task automatic test_abort();
    axi_awvalid_i = 1; axi_awlen_i = 8'd3; axi_awburst_i = BURST_WRAP; axi_awaddr_i = 23'h80;
    axi_arvalid_i = 1; axi_arlen_i = 8'd3; axi_arburst_i = BURST_FIXED; axi_araddr_i = 23'h80;
    tick();
    axi_awvalid_i = 0; axi_arvalid_i = 0;
    checks++;
    if ({wr_abort_o, rd_abort_o, mem_wrreq_o, mem_rdreq_o, axi_awready_o} !== 5'b11001) begin
      errors++;
      $display("[TB] FAIL abort_burst: got wab=%b rab=%b wreq=%b rreq=%b rdy=%b expected 1 1 0 0 1",
               wr_abort_o, rd_abort_o, mem_wrreq_o, mem_rdreq_o, axi_awready_o);
    end
    tick();
    checks++;
    if ({wr_abort_o, rd_abort_o, mem_wrreq_o, mem_rdreq_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL abort_pulse: got wab=%b rab=%b wreq=%b rreq=%b expected 0 0 0 0",
               wr_abort_o, rd_abort_o, mem_wrreq_o, mem_rdreq_o);
    end
    // Error together with ack on the second request of a 4-request burst.
    axi_awvalid_i = 1; axi_awlen_i = 8'd15; axi_awburst_i = BURST_INCR; axi_awaddr_i = 23'h0;
    tick();
    axi_awvalid_i = 0;
    mem_wrack_i = 1;
    tick();
    checks++;
    if ({mem_wrreq_o, mem_wradr_o, wr_abort_o} !== {1'b1, 22'h8, 1'b0}) begin
      errors++;
      $display("[TB] FAIL err_second: got req=%b adr=%h ab=%b expected 1 8 0",
               mem_wrreq_o, mem_wradr_o, wr_abort_o);
    end
    mem_wrerr_i = 1;
    tick();
    mem_wrerr_i = 0; mem_wrack_i = 0;
    checks++;
    if ({wr_abort_o, mem_wrreq_o, axi_awready_o} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL err_abort: got ab=%b req=%b rdy=%b expected 1 0 1",
               wr_abort_o, mem_wrreq_o, axi_awready_o);
    end
    tick();
    checks++;
    if ({wr_abort_o, mem_wrreq_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL err_after: got ab=%b req=%b expected 0 0", wr_abort_o, mem_wrreq_o);
    end
  endtask

  task automatic test_reset_mid();
    axi_awvalid_i = 1; axi_awid_i = 4'd6; axi_awlen_i = 8'd15;
    axi_awburst_i = BURST_INCR; axi_awaddr_i = 23'h200;
    tick();
    axi_awvalid_i = 0;
    mem_wrack_i = 1;
    tick(); tick();
    mem_wrack_i = 0;
    checks++;
    if ({mem_wrreq_o, mem_wradr_o} !== {1'b1, 22'h110}) begin
      errors++;
      $display("[TB] FAIL rst_third: got req=%b adr=%h expected 1 110", mem_wrreq_o, mem_wradr_o);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({mem_wrreq_o, mem_wrlst_o, axi_awready_o, wr_abort_o, mem_wrtid_o, mem_wradr_o} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid: got req=%b lst=%b rdy=%b ab=%b tid=%h adr=%h expected all 0",
               mem_wrreq_o, mem_wrlst_o, axi_awready_o, wr_abort_o, mem_wrtid_o, mem_wradr_o);
    end
    rst_n = 1'b1;
    mem_wrack_i = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (mem_wrreq_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_noreq%0d: got req=%b expected 0", i, mem_wrreq_o);
      end
    end
    mem_wrack_i = 0;
  endtask

  task automatic test_concurrent();
    axi_awvalid_i = 1; axi_awid_i = 4'd5; axi_awlen_i = 8'd7;
    axi_awburst_i = BURST_INCR; axi_awaddr_i = 23'h400;
    axi_arvalid_i = 1; axi_arid_i = 4'd9; axi_arlen_i = 8'd3;
    axi_arburst_i = BURST_INCR; axi_araddr_i = 23'h800;
    tick();
    axi_awvalid_i = 0; axi_arvalid_i = 0;
    checks++;
    if ({mem_wrreq_o, mem_wrtid_o, mem_wradr_o, mem_wrlst_o} !== {1'b1, 4'd5, 22'h200, 1'b0}) begin
      errors++;
      $display("[TB] FAIL conc_wr: got req=%b tid=%h adr=%h lst=%b expected 1 5 200 0",
               mem_wrreq_o, mem_wrtid_o, mem_wradr_o, mem_wrlst_o);
    end
    checks++;
    if ({mem_rdreq_o, mem_rdtid_o, mem_rdadr_o, mem_rdlst_o} !== {1'b1, 4'd9, 22'h400, 1'b1}) begin
      errors++;
      $display("[TB] FAIL conc_rd: got req=%b tid=%h adr=%h lst=%b expected 1 9 400 1",
               mem_rdreq_o, mem_rdtid_o, mem_rdadr_o, mem_rdlst_o);
    end
    mem_rdack_i = 1;
    tick();
    mem_rdack_i = 0;
    checks++;
    if ({mem_rdreq_o, mem_wrreq_o, mem_wradr_o} !== {1'b0, 1'b1, 22'h200}) begin
      errors++;
      $display("[TB] FAIL conc_rdack: got rdreq=%b wrreq=%b wradr=%h expected 0 1 200",
               mem_rdreq_o, mem_wrreq_o, mem_wradr_o);
    end
    mem_wrack_i = 1;
    tick();
    checks++;
    if ({mem_wrreq_o, mem_wradr_o, mem_wrlst_o} !== {1'b1, 22'h208, 1'b1}) begin
      errors++;
      $display("[TB] FAIL conc_wrnext: got req=%b adr=%h lst=%b expected 1 208 1",
               mem_wrreq_o, mem_wradr_o, mem_wrlst_o);
    end
    tick();
    mem_wrack_i = 0;
    checks++;
    if ({mem_wrreq_o, axi_awready_o, axi_arready_o} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL conc_done: got req=%b awrdy=%b arrdy=%b expected 0 1 1",
               mem_wrreq_o, axi_awready_o, axi_arready_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_concurrent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_axi_req.md
# ddr3_axi_req

Upstream request sequencer for the DDR3 memory controller FSM. It accepts AXI4 write-address (AW) and read-address (AR) bursts and splits each one into BL8 requests on the FSM's `mem_wr*` and `mem_rd*` request/acknowledge ports, one request per 16 bytes. Write and read sequencing are fully independent. Data (W/R/B channels) is handled elsewhere; this block carries only addresses and transaction IDs.

## Interface

Parameters:
- `WIDTH`, 32: AXI data width; fixed at 32 (four beats per BL8 on a 16-bit DDR3 device).
- `ADDRS`, 22: FSM address width, in 16-bit DDR-word units.
- `REQID`, 4: transaction ID width.

Ports:
- `clock` in 1: the single clock for the block.
- `rst_n` in 1: reset, synchronous, active-low.
- `axi_awvalid_i` in 1, `axi_awready_o` out 1: AW handshake.
- `axi_awid_i` in REQID: write transaction ID.
- `axi_awlen_i` in 8: AXI burst length minus 1.
- `axi_awburst_i` in 2: burst type; only 2'b01 (INCR) is supported.
- `axi_awaddr_i` in ADDRS+1: byte address.
- `axi_arvalid_i`, `axi_arready_o`, `axi_arid_i`, `axi_arlen_i`, `axi_arburst_i`, `axi_araddr_i`: the same set for the AR channel.
- `mem_wrreq_o` out 1, `mem_wrack_i` in 1: write request/acknowledge.
- `mem_wrlst_o` out 1: marks the final BL8 of the burst.
- `mem_wrerr_i` in 1: error indication from the FSM.
- `mem_wrtid_o` out REQID: transaction ID.
- `mem_wradr_o` out ADDRS: BL8 start address.
- `mem_rdreq_o`, `mem_rdack_i`, `mem_rdlst_o`, `mem_rderr_i`, `mem_rdtid_o`, `mem_rdadr_o`: the same set for reads.
- `wr_abort_o` out 1, `rd_abort_o` out 1: one-cycle pulses, asserted on an unsupported burst type or an FSM error.

## Operation

Each channel runs its own copy of a two-state FSM with states IDLE and BUSY. The behaviour below is written for the write channel; the read channel is identical.

IDLE:
- `axi_awready_o` = 1.
- On `awvalid & awready` with INCR:
  - Latch the ID.
  - Latch address = `awaddr[ADDRS:1]` with bits [2:0] forced to 0 (aligned down to BL8).
  - Latch remaining count = `awlen[7:2]`. `awlen[1:0]` is ignored, so the request count is `awlen[7:2]+1`, range 1..64.
  - Go to BUSY.
- On `awvalid & awready` with a non-INCR burst:
  - Accept the address.
  - Pulse `wr_abort_o` on the next cycle.
  - Stay in IDLE and issue no requests.

BUSY:
- `axi_awready_o` = 0 and `mem_wrreq_o` = 1.
- `mem_wrlst_o` = (count == 0).
- `mem_wrtid_o`/`mem_wradr_o` hold their latched values and do not change while the request is unacknowledged.
- On `mem_wrack_i` with count > 0:
  - Address += 8, modulo 2^ADDRS (wraps to 0).
  - Count -= 1.
  - Request stays asserted.
- On `mem_wrack_i` with count == 0: go to IDLE.
- On `mem_wrerr_i` (in any BUSY cycle, with or without ack):
  - Drop the remaining requests.
  - Pulse the abort output.
  - Go to IDLE.
  - Error takes priority over a simultaneous ack.

`mem_wrack_i` and `mem_wrerr_i` are ignored while in IDLE.

Reset: while `rst_n` = 0 at a clock edge, all outputs are 0 and both FSMs are in IDLE. A reset mid-burst discards the burst; no further requests are issued after reset is released.

## Timing

- AW handshake at edge N: `mem_wrreq_o` = 1 from edge N+1.
- Back-to-back requests: a new address is presented the cycle after each ack, so one BL8 can complete per cycle if ack stays high.
- After the final ack at edge M: `mem_wrreq_o` = 0 and `axi_awready_o` = 1 from edge M+1. The next AW can be accepted at edge M+1, giving a one-cycle bubble between bursts.
- Abort pulse: asserted for exactly one cycle, at edge N+1 after the triggering event at edge N.
- All outputs are registered; there are no combinational paths from input to output.
- The write and read sequencers do not interact; simultaneous AW and AR handshakes are both accepted.

## Structure

- Sub-module `ddr3_axi_seq` contains one channel FSM (latch, counter, address incrementer). It is instantiated twice, once for writes and once for reads.
- The shared package holds:
  - the burst-type constants (FIXED, INCR, WRAP);
  - BL8 stride = 8;
  - beats-per-BL8 = 4.

## Test plan

- **Single burst.** AW: len=3, addr=0x40, id=2, INCR. Expect one write request with adr=0x20, lst=1, tid=2. Expect `awready` high again one cycle after the ack.
- **Multi-BL8 burst, early ack.** AW: len=15, addr=0x100. With ack held at 1, expect 4 requests on consecutive cycles with adr 0x80, 0x88, 0x90, 0x98, and lst=1 only on 0x98.
- **Address wrap and misalignment.** AR: len=7, addr = 2^(ADDRS+1)-16 plus 2 (unaligned). Expect adr = 2^ADDRS-8, then 0, with lst on the second request.
- **Unsupported burst and error abort.** Case 1: AW with burst=WRAP. Expect `wr_abort_o` pulsed once and `mem_wrreq_o` never asserted. Case 2: during a 4-request burst, assert `mem_wrerr_i` with ack on the 2nd request. Expect the abort pulse, req=0 next cycle, and the FSM back in IDLE.
- **Reset and concurrency.**
  - Reset mid-burst: drop `rst_n` during the 3rd request. Expect all outputs 0 on the next edge and no requests after release.
  - Simultaneous channels: issue AW and AR on the same edge. Expect both requests asserted on the next cycle, with independent ack progress.
